// File: rtl/fw_pkg.sv
// Shared defaults, phase encodings and block-count helpers for the FW overlap feeder.
package fw_pkg;

    localparam int EW_DEF    = 16;
    localparam int LANES_DEF = 4;
    localparam int N_DEF     = 8;
    localparam int MAX_NBLK  = 3;

    localparam logic [1:0] PHASE_00 = 2'b00;
    localparam logic [1:0] PHASE_01 = 2'b01;
    localparam logic [1:0] PHASE_10 = 2'b10;
    localparam logic [1:0] PHASE_11 = 2'b11;

    typedef enum logic {FILL, WAIT} wr_state_t;
    typedef enum logic {IDLE, RUN}  rd_state_t;

    function automatic int calc_wpb(input int n, input int lanes);
        return (n * n) / lanes;
    endfunction

    function automatic int nblk(input logic [1:0] phase);
        int blocks;
        case (phase)
            PHASE_00:           blocks = 1;
            PHASE_01, PHASE_10: blocks = 2;
            default:            blocks = 3;
        endcase
        return blocks;
    endfunction

endpackage

// File: rtl/fw_bank_ram.sv
// Simple dual-port word store holding both ping-pong banks, with a registered read port.
module fw_bank_ram #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 96,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the output register is reset; it holds its value whenever no read is issued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fw_overlap_feeder.sv
// Ping-pong group buffer: one bank fills from the input while the other streams to the FW core.
module fw_overlap_feeder
    import fw_pkg::*;
#(
    parameter int EW    = EW_DEF,
    parameter int LANES = LANES_DEF,
    parameter int N     = N_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [LANES*EW-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_phase,
    input  logic                inhibit,
    output logic [LANES*EW-1:0] out_data,
    output logic                out_valid,
    output logic [1:0]          out_phase,
    output logic                out_last
);

    localparam int WPB        = calc_wpb(N, LANES);
    localparam int BANK_DEPTH = MAX_NBLK * WPB;
    localparam int RAM_DEPTH  = 2 * BANK_DEPTH;
    localparam int AW         = $clog2(RAM_DEPTH);
    localparam int CW         = $clog2(BANK_DEPTH);
    localparam logic [AW-1:0] BANK1_BASE = AW'(BANK_DEPTH);

    if ((N * N) % LANES != 0) begin : g_lanes_check
        $error("fw_overlap_feeder: N*N must be divisible by LANES");
    end

    function automatic logic [CW-1:0] last_word(input logic [1:0] ph);
        return CW'(nblk(ph) * WPB - 1);
    endfunction

    wr_state_t       wr_state, wr_state_d;
    rd_state_t       rd_state, rd_state_d;
    logic            wr_bank, rd_bank;
    logic [CW-1:0]   wr_cnt, rd_cnt, rd_cnt_d;
    logic [1:0]      full, full_d;
    logic [1:0]      bank_phase [2];

    logic            accept, wr_last, release_bank;
    logic [1:0]      wr_phase;
    logic            re;
    logic [AW-1:0]   waddr, raddr, rd_base;

    assign accept       = in_valid && in_ready;
    assign wr_phase     = (wr_cnt == '0) ? in_phase : bank_phase[wr_bank];
    assign wr_last      = accept && (wr_cnt == last_word(wr_phase));
    assign release_bank = (rd_state == RUN) && !inhibit && (rd_cnt == last_word(bank_phase[rd_bank]));
    assign waddr        = (wr_bank ? BANK1_BASE : '0) + AW'(wr_cnt);
    assign rd_base      = rd_bank ? BANK1_BASE : '0;

    assign out_valid = (rd_state == RUN) && !inhibit;
    assign out_last  = out_valid && (rd_cnt == last_word(bank_phase[rd_bank]));
    assign out_phase = bank_phase[rd_bank];

    // Release and completion always hit different banks: writes go only to a non-full bank, reads only from a full one.
    always_comb begin
        full_d = full;
        if (release_bank) begin
            full_d[rd_bank] = 1'b0;
        end
        if (wr_last) begin
            full_d[wr_bank] = 1'b1;
        end

        wr_state_d = wr_state;
        unique case (wr_state)
            FILL: if (wr_last && full_d[~wr_bank]) wr_state_d = WAIT;
            WAIT: if (!full_d[wr_bank])            wr_state_d = FILL;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state;
        rd_cnt_d   = rd_cnt;
        re         = 1'b0;
        raddr      = rd_base + AW'(rd_cnt);
        unique case (rd_state)
            IDLE: begin
                rd_cnt_d = '0;
                if (full[rd_bank]) begin
                    re         = 1'b1;
                    raddr      = rd_base;
                    rd_state_d = RUN;
                end
            end
            RUN: begin
                if (!inhibit) begin
                    if (release_bank) begin
                        rd_state_d = IDLE;
                        rd_cnt_d   = '0;
                    end else begin
                        re       = 1'b1;
                        raddr    = rd_base + AW'(rd_cnt) + AW'(1);
                        rd_cnt_d = rd_cnt + CW'(1);
                    end
                end
            end
        endcase
    end

    // in_ready tracks the write FSM: FILL means the current write bank has room.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_state      <= FILL;
            rd_state      <= IDLE;
            wr_bank       <= 1'b0;
            rd_bank       <= 1'b0;
            wr_cnt        <= '0;
            rd_cnt        <= '0;
            full          <= '0;
            in_ready      <= 1'b0;
            bank_phase[0] <= '0;
            bank_phase[1] <= '0;
        end else begin
            wr_state <= wr_state_d;
            rd_state <= rd_state_d;
            wr_bank  <= wr_bank ^ wr_last;
            rd_bank  <= rd_bank ^ release_bank;
            rd_cnt   <= rd_cnt_d;
            full     <= full_d;
            in_ready <= (wr_state_d == FILL);
            if (accept) begin
                wr_cnt <= wr_last ? '0 : wr_cnt + CW'(1);
                if (wr_cnt == '0) begin
                    bank_phase[wr_bank] <= in_phase;
                end
            end
        end
    end

    fw_bank_ram #(
        .WIDTH (LANES * EW),
        .DEPTH (RAM_DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (accept),
        .waddr (waddr),
        .wdata (in_data),
        .re    (re),
        .raddr (raddr),
        .rdata (out_data)
    );

endmodule
